// File: rtl/id_immgen_pipe.sv
// Two-stage pipelined immediate generator with pc+imm and a valid/ready handshake.
// Optional feature macro: IMMGEN_ZIMM_EN (enables the csr zimm format for gen_type 001).
module id_immgen_pipe #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6,
  parameter int GEN_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [GEN_W-1:0]   in_gen_type,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [XLEN-1:0]    out_pc_imm
);

  localparam logic [GEN_W-1:0] GEN_NONE  = GEN_W'(3'd0);
  localparam logic [GEN_W-1:0] GEN_ZIMM  = GEN_W'(3'd1);
  localparam logic [GEN_W-1:0] GEN_SHIFT = GEN_W'(3'd2);
  localparam logic [GEN_W-1:0] GEN_S     = GEN_W'(3'd3);
  localparam logic [GEN_W-1:0] GEN_U     = GEN_W'(3'd4);
  localparam logic [GEN_W-1:0] GEN_J     = GEN_W'(3'd5);
  localparam logic [GEN_W-1:0] GEN_I     = GEN_W'(3'd6);
  localparam logic [GEN_W-1:0] GEN_B     = GEN_W'(3'd7);

  logic                s1_valid_r;
  logic                s2_valid_r;
  logic [31:0]         s1_imm_r;
  logic [SHAMT_W-1:0]  s1_shamt_r;
  logic [XLEN-1:0]     s1_pc_r;
  logic [31:0]         imm_pre_s;
  logic [XLEN-1:0]     imm_ext_s;
  logic                s2_adv_s;
  logic                accept_s;
  logic                s1_to_s2_s;
  logic                unused_s;

  assign s2_adv_s   = ~s2_valid_r | out_ready;
  assign in_ready   = ~s1_valid_r | s2_adv_s;
  assign accept_s   = in_valid & in_ready;
  assign s1_to_s2_s = s1_valid_r & s2_adv_s;
  assign out_valid  = s2_valid_r;
  assign imm_ext_s  = XLEN'($signed(s1_imm_r));
  assign unused_s   = ^in_inst[6:0];

  // Format decode into the 32-bit pre-immediate
  always_comb begin
    imm_pre_s = 32'h0000_0000;
    case (in_gen_type)
      GEN_NONE:  imm_pre_s = 32'h0000_0000;
`ifdef IMMGEN_ZIMM_EN
      GEN_ZIMM:  imm_pre_s = {27'd0, in_inst[19:15]};
`else
      GEN_ZIMM:  imm_pre_s = 32'h0000_0000;
`endif
      GEN_SHIFT: imm_pre_s = {26'd0, in_inst[25:20]};
      GEN_S:     imm_pre_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      GEN_U:     imm_pre_s = {in_inst[31:12], 12'd0};
      GEN_J:     imm_pre_s = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      GEN_I:     imm_pre_s = {{20{in_inst[31]}}, in_inst[31:20]};
      GEN_B:     imm_pre_s = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      default:   imm_pre_s = 32'h0000_0000;
    endcase
  end

  // Stage 1: valid tracking and capture of pre-immediate, shamt and pc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_imm_r   <= 32'h0000_0000;
      s1_shamt_r <= {SHAMT_W{1'b0}};
      s1_pc_r    <= {XLEN{1'b0}};
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_to_s2_s) begin
        s1_valid_r <= 1'b0;
      end
      // flush kills the valid bit only; data simply keeps its last value
      if (accept_s && !flush) begin
        s1_imm_r   <= imm_pre_s;
        s1_shamt_r <= in_inst[20+SHAMT_W-1:20];
        s1_pc_r    <= in_pc;
      end
    end
  end

  // Stage 2: sign extension to XLEN and pc-relative sum, driving the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      out_imm    <= {XLEN{1'b0}};
      out_shamt  <= {SHAMT_W{1'b0}};
      out_pc_imm <= {XLEN{1'b0}};
    end else begin
      if (flush) begin
        s2_valid_r <= 1'b0;
      end else if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s1_to_s2_s && !flush) begin
        out_imm    <= imm_ext_s;
        out_shamt  <= s1_shamt_r;
        out_pc_imm <= s1_pc_r + imm_ext_s;
      end
    end
  end

endmodule

// File: tb/tb_id_immgen_pipe.sv
// Scoreboard bench for id_immgen_pipe: directed vectors, backpressure, flush and async reset.
module tb_id_immgen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_gen_type;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [5:0]  out_shamt;
  logic [63:0] out_pc_imm;

  id_immgen_pipe #(.XLEN(64), .SHAMT_W(6), .GEN_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_gen_type(in_gen_type), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_shamt(out_shamt), .out_pc_imm(out_pc_imm)
  );

  typedef struct {
    logic [63:0] imm;
    logic [5:0]  shamt;
    logic [63:0] pci;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] inst_v [9];
  logic [2:0]  gen_v  [9];
  logic [63:0] pc_v   [9];
  logic [63:0] imm_v  [9];
  logic [5:0]  sh_v   [9];
  logic [63:0] pci_v  [9];

  logic        stall_chk = 1'b0;
  logic [63:0] h_imm, h_pci;
  logic [5:0]  h_sh;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    inst_v[0] = 32'hFFF00093; gen_v[0] = 3'b110; pc_v[0] = 64'h1000;
    imm_v[0] = 64'hFFFFFFFF_FFFFFFFF; sh_v[0] = 6'h3F; pci_v[0] = 64'h0FFF;
    inst_v[1] = 32'hFE000EE3; gen_v[1] = 3'b111; pc_v[1] = 64'h8000_0010;
    imm_v[1] = 64'hFFFFFFFF_FFFFFFFC; sh_v[1] = 6'h20; pci_v[1] = 64'h00000000_8000000C;
    inst_v[2] = 32'h800000B7; gen_v[2] = 3'b100; pc_v[2] = 64'h10;
    imm_v[2] = 64'hFFFFFFFF_80000000; sh_v[2] = 6'h00; pci_v[2] = 64'hFFFFFFFF_80000010;
    inst_v[3] = 32'h123450B7; gen_v[3] = 3'b100; pc_v[3] = 64'h100;
    imm_v[3] = 64'h00000000_12345000; sh_v[3] = 6'h23; pci_v[3] = 64'h00000000_12345100;
    inst_v[4] = 32'h000F8073; gen_v[4] = 3'b001; pc_v[4] = 64'h2000; sh_v[4] = 6'h00;
`ifdef IMMGEN_ZIMM_EN
    imm_v[4] = 64'h1F; pci_v[4] = 64'h201F;
`else
    imm_v[4] = 64'h0;  pci_v[4] = 64'h2000;
`endif
    inst_v[5] = 32'h03F01013; gen_v[5] = 3'b010; pc_v[5] = 64'h0;
    imm_v[5] = 64'h3F; sh_v[5] = 6'h3F; pci_v[5] = 64'h3F;
    inst_v[6] = 32'hFE112E23; gen_v[6] = 3'b011; pc_v[6] = 64'h100;
    imm_v[6] = 64'hFFFFFFFF_FFFFFFFC; sh_v[6] = 6'h21; pci_v[6] = 64'hFC;
    inst_v[7] = 32'h0080006F; gen_v[7] = 3'b101; pc_v[7] = 64'h400;
    imm_v[7] = 64'h8; sh_v[7] = 6'h08; pci_v[7] = 64'h408;
    inst_v[8] = 32'hFFFFFFFF; gen_v[8] = 3'b000; pc_v[8] = 64'h55;
    imm_v[8] = 64'h0; sh_v[8] = 6'h3F; pci_v[8] = 64'h55;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one beat; it is accepted at the posedge following a negedge where in_ready is high
  task automatic send(input int k, input bit expect_it);
    bit done = 1'b0;
    exp_t e;
    in_inst = inst_v[k]; in_gen_type = gen_v[k]; in_pc = pc_v[k]; in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        if (expect_it) begin
          e.imm = imm_v[k]; e.shamt = sh_v[k]; e.pci = pci_v[k];
          sb.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pop and compare on every handshake, and check hold stability during stalls
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_chk = 1'b0;
    end else begin
      if (stall_chk) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_imm", out_imm, h_imm);
        check("stall_pci", out_pc_imm, h_pci);
        check("stall_shamt", {58'd0, out_shamt}, {58'd0, h_sh});
      end
      stall_chk = out_valid && !out_ready && !flush;
      h_imm = out_imm; h_pci = out_pc_imm; h_sh = out_shamt;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("imm", out_imm, e.imm);
          check("shamt", {58'd0, out_shamt}, {58'd0, e.shamt});
          check("pc_imm", out_pc_imm, e.pci);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'd0; in_gen_type = 3'd0; in_pc = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_pci", out_pc_imm, 64'd0);
    check("rst_shamt", {58'd0, out_shamt}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Latency: accepted at P1, out_valid after P2
    send(0, 1'b1);
    @(negedge clk);
    check("lat_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_cycle2", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    for (int k = 1; k < 9; k++) send(k, 1'b1);
    drain();

    // Backpressure: 4 beats, out_ready low for 3 cycles
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(k, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both stages full; the beat offered in the flush cycle is dropped
    out_ready = 1'b0;
    send(1, 1'b0);
    send(2, 1'b0);
    in_inst = inst_v[3]; in_gen_type = gen_v[3]; in_pc = pc_v[3];
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_inst = inst_v[5]; in_gen_type = gen_v[5]; in_pc = pc_v[5];
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_discard", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    send(4, 1'b1);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(5, 1'b0);
    send(6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_imm", out_imm, 64'd0);
    check("arst_pci", out_pc_imm, 64'd0);
    check("arst_shamt", {58'd0, out_shamt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(7, 1'b1);
    @(negedge clk);
    check("post_rst_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("post_rst_cycle2", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
